// File: rtl/multi_cycle_shifter_if.sv
// Request/result bundle for the iterative shifter. The controller drives the
// operation fields and start; the shifter returns busy, done and the result.
interface multi_cycle_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] din;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, din, cnt, dir, mode,
        input  busy, done, dout
    );

    modport slave (
        input  start, din, cnt, dir, mode,
        output busy, done, dout
    );
endinterface

// File: rtl/multi_cycle_shifter.sv
// Iterative rotate/logical/arithmetic shifter that moves one bit per clock.
// Define MULTI_CYCLE_SHIFTER_DUAL_STEP_EN to advance two positions per clock.
module multi_cycle_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_cycle_shifter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    // Arithmetic left shifts fill with zero, so only a right arithmetic shift differs from logical.
    function automatic logic [WIDTH-1:0] step_once(
        input logic [WIDTH-1:0] w,
        input logic             right,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        case (m)
            2'b00: begin
                if (right) r = {w[0], w[WIDTH-1:1]};
                else       r = {w[WIDTH-2:0], w[WIDTH-1]};
            end
            2'b10: begin
                if (right) r = {w[WIDTH-1], w[WIDTH-1:1]};
                else       r = {w[WIDTH-2:0], 1'b0};
            end
            default: begin
                if (right) r = {1'b0, w[WIDTH-1:1]};
                else       r = {w[WIDTH-2:0], 1'b0};
            end
        endcase
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= {WIDTH{1'b0}};
            ctr_q   <= {CNT_W{1'b0}};
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            ctr_q   <= ctr_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state logic: accept in IDLE, step in SHIFT, publish when the counter runs out.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        ctr_d   = ctr_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    work_d  = bus.din;
                    ctr_d   = bus.cnt;
                    dir_d   = bus.dir;
                    mode_d  = bus.mode;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ctr_q == {CNT_W{1'b0}}) begin
                    dout_d  = work_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
`ifdef MULTI_CYCLE_SHIFTER_DUAL_STEP_EN
                    if (ctr_q > CNT_W'(1)) begin
                        work_d = step_once(step_once(work_q, dir_q, mode_q), dir_q, mode_q);
                        ctr_d  = ctr_q - CNT_W'(2);
                    end else begin
                        work_d = step_once(work_q, dir_q, mode_q);
                        ctr_d  = ctr_q - CNT_W'(1);
                    end
`else
                    work_d = step_once(work_q, dir_q, mode_q);
                    ctr_d  = ctr_q - CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;

endmodule
